// File: rtl/reg_file_ext.sv
// reg_file_ext: DEPTH x DATA_WIDTH register file with single-cycle read/write handshakes,
// per-register write protection and out-of-range / collision error pulses.
module reg_file_ext #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 4,
    parameter int                    DEPTH      = 16,
    parameter logic [DATA_WIDTH-1:0] REG2_RST   = 8'b0100_0001,
    parameter logic [DATA_WIDTH-1:0] REG3_RST   = 8'b0010_0000,
    parameter logic [DEPTH-1:0]      RO_MASK    = '0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  WrEn,
    input  logic                  RdEn,
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic [DATA_WIDTH-1:0] WrData,
    output logic [DATA_WIDTH-1:0] RdData,
    output logic                  RdData_Valid,
    output logic                  Wr_Ack,
    output logic                  Addr_Err,
    output logic [DATA_WIDTH-1:0] REG0,
    output logic [DATA_WIDTH-1:0] REG1,
    output logic [DATA_WIDTH-1:0] REG2,
    output logic [DATA_WIDTH-1:0] REG3
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdData;
    logic                  r_rdValid;
    logic                  r_wrAck;
    logic                  r_addrErr;

    logic [IDX_W-1:0]      w_idx;
    logic                  w_inRange;
    logic                  w_readOnly;
    logic                  w_collision;
    logic                  w_wrReq;
    logic                  w_rdReq;
    logic                  w_wrOk;
    logic                  w_err;

    // Range check uses the full address so out-of-range indices never alias onto real registers.
    assign w_idx       = Address[IDX_W-1:0];
    assign w_inRange   = ({1'b0, Address} < (ADDR_WIDTH + 1)'(DEPTH));
    assign w_readOnly  = RO_MASK[w_idx];
    assign w_collision = WrEn & RdEn;
    assign w_wrReq     = WrEn & ~RdEn;
    assign w_rdReq     = RdEn & ~WrEn;
    assign w_wrOk      = w_wrReq & w_inRange & ~w_readOnly;
    assign w_err       = w_collision
                       | (w_wrReq & ~(w_inRange & ~w_readOnly))
                       | (w_rdReq & ~w_inRange);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= (i == 2) ? REG2_RST : (i == 3) ? REG3_RST : '0;
            end
        end else if (w_wrOk) begin
            r_mem[w_idx] <= WrData;
        end
    end

    // Out-of-range reads still complete (data 0) so the requester never waits on a handshake.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_rdData  <= '0;
            r_rdValid <= 1'b0;
            r_wrAck   <= 1'b0;
            r_addrErr <= 1'b0;
        end else begin
            r_rdValid <= w_rdReq;
            r_wrAck   <= w_wrOk;
            r_addrErr <= w_err;
            if (w_rdReq) begin
                r_rdData <= w_inRange ? r_mem[w_idx] : '0;
            end
        end
    end

    assign RdData       = r_rdData;
    assign RdData_Valid = r_rdValid;
    assign Wr_Ack       = r_wrAck;
    assign Addr_Err     = r_addrErr;
    assign REG0         = r_mem[0];
    assign REG1         = r_mem[1];
    assign REG2         = r_mem[2];
    assign REG3         = r_mem[3];

endmodule

// File: tb/tb_reg_file_ext.sv
// tb_reg_file_ext: drives a default instance and a DEPTH=12 / register-3-read-only instance
// with shared stimulus, checking both against a behavioural register-file model.
module tb_reg_file_ext;

    logic       CLK;
    logic       RST;
    logic       WrEn;
    logic       RdEn;
    logic [3:0] Address;
    logic [7:0] WrData;

    logic [7:0] rdData  [2];
    logic       rdValid [2];
    logic       wrAck   [2];
    logic       addrErr [2];
    logic [7:0] reg0    [2];
    logic [7:0] reg1    [2];
    logic [7:0] reg2    [2];
    logic [7:0] reg3    [2];

    int nChecks = 0;
    int nFails  = 0;

    // Behavioural model state, one slot per instance.
    int         depthOf [2] = '{16, 12};
    logic [15:0] roOf   [2] = '{16'h0000, 16'h0008};
    logic [7:0] mMem    [2][16];
    logic [7:0] mRd     [2];
    logic       mValid  [2];
    logic       mAck    [2];
    logic       mErr    [2];

    typedef struct {
        logic       we;
        logic       re;
        logic [3:0] addr;
        logic [7:0] data;
        logic [7:0] expRd;
        logic       expValid;
        logic       expAck;
        logic       expErr;
    } vec_t;

    vec_t vecs [11];

    reg_file_ext u_dutA (
        .CLK(CLK), .RST(RST), .WrEn(WrEn), .RdEn(RdEn), .Address(Address), .WrData(WrData),
        .RdData(rdData[0]), .RdData_Valid(rdValid[0]), .Wr_Ack(wrAck[0]), .Addr_Err(addrErr[0]),
        .REG0(reg0[0]), .REG1(reg1[0]), .REG2(reg2[0]), .REG3(reg3[0])
    );

    reg_file_ext #(
        .DEPTH(12),
        .RO_MASK(12'h008)
    ) u_dutB (
        .CLK(CLK), .RST(RST), .WrEn(WrEn), .RdEn(RdEn), .Address(Address), .WrData(WrData),
        .RdData(rdData[1]), .RdData_Valid(rdValid[1]), .Wr_Ack(wrAck[1]), .Addr_Err(addrErr[1]),
        .REG0(reg0[1]), .REG1(reg1[1]), .REG2(reg2[1]), .REG3(reg3[1])
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic modelReset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 16; i++) mMem[k][i] = 8'h00;
            mMem[k][2] = 8'h41;
            mMem[k][3] = 8'h20;
            mRd[k]     = 8'h00;
            mValid[k]  = 1'b0;
            mAck[k]    = 1'b0;
            mErr[k]    = 1'b0;
        end
    endtask

    task automatic modelStep(input logic we, input logic re, input logic [3:0] addr, input logic [7:0] data);
        for (int k = 0; k < 2; k++) begin
            mValid[k] = 1'b0;
            mAck[k]   = 1'b0;
            mErr[k]   = 1'b0;
            if (we && re) begin
                mErr[k] = 1'b1;
            end else if (we) begin
                if (int'(addr) < depthOf[k] && !roOf[k][addr]) begin
                    mMem[k][addr] = data;
                    mAck[k]       = 1'b1;
                end else begin
                    mErr[k] = 1'b1;
                end
            end else if (re) begin
                mValid[k] = 1'b1;
                if (int'(addr) < depthOf[k]) begin
                    mRd[k] = mMem[k][addr];
                end else begin
                    mRd[k]  = 8'h00;
                    mErr[k] = 1'b1;
                end
            end
        end
    endtask

    task automatic compareModel(input string tag);
        for (int k = 0; k < 2; k++) begin
            string p;
            p = $sformatf("%s[%0d]", tag, k);
            checkOutput({p, " RdData"},       rdData[k],  mRd[k]);
            checkOutput({p, " RdData_Valid"}, rdValid[k], mValid[k]);
            checkOutput({p, " Wr_Ack"},       wrAck[k],   mAck[k]);
            checkOutput({p, " Addr_Err"},     addrErr[k], mErr[k]);
            checkOutput({p, " REG0"},         reg0[k],    mMem[k][0]);
            checkOutput({p, " REG1"},         reg1[k],    mMem[k][1]);
            checkOutput({p, " REG2"},         reg2[k],    mMem[k][2]);
            checkOutput({p, " REG3"},         reg3[k],    mMem[k][3]);
        end
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic applyStimulus(input logic we, input logic re, input logic [3:0] addr,
                                 input logic [7:0] data, input string tag);
        WrEn    = we;
        RdEn    = re;
        Address = addr;
        WrData  = data;
        modelStep(we, re, addr, data);
        @(posedge CLK);
        @(negedge CLK);
        compareModel(tag);
    endtask

    initial begin
        RST     = 1'b0;
        WrEn    = 1'b0;
        RdEn    = 1'b0;
        Address = 4'd0;
        WrData  = 8'h00;
        modelReset();

        vecs[0]  = '{1'b1, 1'b0, 4'd1,  8'h5A, 8'h00, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 4'd1,  8'h00, 8'h5A, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 4'd0,  8'h00, 8'h5A, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 4'd0,  8'h77, 8'h5A, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 1'b1, 4'd0,  8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 4'd2,  8'h00, 8'h41, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 4'd3,  8'h00, 8'h20, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 4'd15, 8'hC3, 8'h20, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 4'd15, 8'h00, 8'hC3, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 4'd2,  8'h99, 8'hC3, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 4'd2,  8'h00, 8'h99, 1'b1, 1'b0, 1'b0};

        repeat (3) @(negedge CLK);
        RST = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            checkOutput("reset REG0", reg0[k], 8'h00);
            checkOutput("reset REG1", reg1[k], 8'h00);
            checkOutput("reset REG2", reg2[k], 8'h41);
            checkOutput("reset REG3", reg3[k], 8'h20);
            checkOutput("reset RdData", rdData[k], 8'h00);
            checkOutput("reset pulses", {rdValid[k], wrAck[k], addrErr[k]}, 3'b000);
        end
        @(negedge CLK);

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].data, $sformatf("vec%0d", i));
            checkOutput($sformatf("vec%0d RdData", i),       rdData[0],  vecs[i].expRd);
            checkOutput($sformatf("vec%0d RdData_Valid", i), rdValid[0], vecs[i].expValid);
            checkOutput($sformatf("vec%0d Wr_Ack", i),       wrAck[0],   vecs[i].expAck);
            checkOutput($sformatf("vec%0d Addr_Err", i),     addrErr[0], vecs[i].expErr);
            if (i == 1) checkOutput("write-read REG1", reg1[0], 8'h5A);
            if (i == 3) checkOutput("collision REG0", reg0[0], 8'h00);
        end

        // Out-of-range write then read on the DEPTH=12 instance.
        applyStimulus(1'b1, 1'b0, 4'd13, 8'hFF, "oor_wr");
        checkOutput("oor write Addr_Err", addrErr[1], 1'b1);
        checkOutput("oor write Wr_Ack", wrAck[1], 1'b0);
        applyStimulus(1'b0, 1'b1, 4'd13, 8'h00, "oor_rd");
        checkOutput("oor read RdData", rdData[1], 8'h00);
        checkOutput("oor read RdData_Valid", rdValid[1], 1'b1);
        checkOutput("oor read Addr_Err", addrErr[1], 1'b1);

        // Write to the read-only register 3 on instance B.
        applyStimulus(1'b1, 1'b0, 4'd3, 8'h11, "ro_wr");
        checkOutput("ro write REG3", reg3[1], 8'h20);
        checkOutput("ro write Addr_Err", addrErr[1], 1'b1);
        checkOutput("ro write Wr_Ack", wrAck[1], 1'b0);
        applyStimulus(1'b0, 1'b1, 4'd3, 8'h00, "ro_rd");
        checkOutput("ro read RdData", rdData[1], 8'h20);

        // Reset asserted mid-cycle while a read is pending.
        applyStimulus(1'b1, 1'b0, 4'd2, 8'h33, "pre_rst_wr");
        checkOutput("pre-reset REG2", reg2[0], 8'h33);
        WrEn    = 1'b0;
        RdEn    = 1'b1;
        Address = 4'd2;
        #2;
        RST = 1'b0;
        #1;
        modelReset();
        for (int k = 0; k < 2; k++) begin
            checkOutput("async reset REG2", reg2[k], 8'h41);
            checkOutput("async reset RdData_Valid", rdValid[k], 1'b0);
        end
        @(posedge CLK);
        @(negedge CLK);
        compareModel("in_reset");
        RST = 1'b1;
        applyStimulus(1'b0, 1'b1, 4'd2, 8'h00, "post_rst_rd");
        checkOutput("post-reset read RdData", rdData[0], 8'h41);

        for (int n = 0; n < 400; n++) begin
            logic       we;
            logic       re;
            logic [3:0] addr;
            logic [7:0] data;
            we   = ($urandom_range(0, 99) < 45);
            re   = ($urandom_range(0, 99) < 45);
            addr = 4'($urandom_range(0, 15));
            data = 8'($urandom);
            applyStimulus(we, re, addr, data, $sformatf("rnd%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
